// File: rtl/counter_timebase_pkg.sv
// Shared types and helpers for the counter_timebase prescaler and channels.
// COUNTER_TIMEBASE_ONESHOT_EN adds the one-shot DONE state.
package counter_timebase_pkg;

`ifdef COUNTER_TIMEBASE_ONESHOT_EN
  typedef enum logic [1:0] {
    CH_IDLE = 2'd0,
    CH_RUN  = 2'd1,
    CH_DONE = 2'd2
  } ch_state_e;
`else
  typedef enum logic [1:0] {
    CH_IDLE = 2'd0,
    CH_RUN  = 2'd1
  } ch_state_e;
`endif

  localparam longint NS_PER_S = 64'd1_000_000_000;

  function automatic longint calc_div(
    input longint clk_hz,
    input longint base_ns
  );
    return (clk_hz * base_ns) / NS_PER_S;
  endfunction

  function automatic bit div_exact(
    input longint clk_hz,
    input longint base_ns
  );
    return ((clk_hz * base_ns) % NS_PER_S) == 0;
  endfunction

endpackage

// File: rtl/counter_timebase_ch.sv
// One timebase channel: IDLE/RUN(/DONE) FSM counting base ticks.
// One-shot mode only exists with COUNTER_TIMEBASE_ONESHOT_EN.
module counter_timebase_ch
  import counter_timebase_pkg::*;
#(
  parameter int PW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          advance,
  input  logic          ch_en,
  input  logic [PW-1:0] period,
  input  logic          oneshot,
  output logic          tick,
  output logic [PW-1:0] cnt,
  output logic          busy,
  output logic          done
);

  ch_state_e     st_q, st_d;
  logic [PW-1:0] cnt_d;
  logic [PW-1:0] per_q, per_d;
  logic          tick_d;
  logic          terminal;

  assign terminal = (cnt == per_q - PW'(1));

`ifdef COUNTER_TIMEBASE_ONESHOT_EN
  logic one_q, one_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) one_q <= 1'b0;
    else     one_q <= one_d;
  end
`else
  logic unused_oneshot;
  assign unused_oneshot = oneshot;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q  <= CH_IDLE;
      cnt   <= '0;
      per_q <= '0;
      tick  <= 1'b0;
    end else begin
      st_q  <= st_d;
      cnt   <= cnt_d;
      per_q <= per_d;
      tick  <= tick_d;
    end
  end

  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt;
    per_d  = per_q;
    tick_d = 1'b0;
`ifdef COUNTER_TIMEBASE_ONESHOT_EN
    one_d  = one_q;
`endif
    // Disable outranks everything, including a coincident terminal count.
    if (!ch_en) begin
      st_d  = CH_IDLE;
      cnt_d = '0;
      per_d = '0;
    end else begin
      unique case (st_q)
        CH_IDLE: begin
          if (period != '0) begin
            st_d  = CH_RUN;
            per_d = period;
            cnt_d = '0;
`ifdef COUNTER_TIMEBASE_ONESHOT_EN
            one_d = oneshot;
`endif
          end
        end
        CH_RUN: begin
          if (advance) begin
            if (terminal) begin
              cnt_d  = '0;
              tick_d = 1'b1;
`ifdef COUNTER_TIMEBASE_ONESHOT_EN
              if (one_q) begin
                st_d = CH_DONE;
              end else begin
                per_d = period;
                if (period == '0) st_d = CH_IDLE;
              end
`else
              per_d = period;
              if (period == '0) st_d = CH_IDLE;
`endif
            end else begin
              cnt_d = cnt + PW'(1);
            end
          end
        end
`ifdef COUNTER_TIMEBASE_ONESHOT_EN
        CH_DONE: begin
          st_d = CH_DONE;
        end
`endif
        default: begin
          st_d = CH_IDLE;
        end
      endcase
    end
  end

  assign busy = (st_q == CH_RUN);

`ifdef COUNTER_TIMEBASE_ONESHOT_EN
  assign done = (st_q == CH_DONE);
`else
  assign done = 1'b0;
`endif

endmodule

// File: rtl/counter_timebase.sv
// Prescaled base tick plus NUM_CH periodic/one-shot timer channels.
// Optional one-shot support: define COUNTER_TIMEBASE_ONESHOT_EN.
module counter_timebase
  import counter_timebase_pkg::*;
#(
  parameter int CLK_HZ  = 20_000_000,
  parameter int BASE_NS = 1000,
  parameter int NUM_CH  = 2,
  parameter int PW      = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [NUM_CH-1:0]    ch_en,
  input  logic [NUM_CH*PW-1:0] ch_period,
  input  logic [NUM_CH-1:0]    ch_oneshot,
  output logic               base_tick,
  output logic [NUM_CH-1:0]    ch_tick,
  output logic [NUM_CH*PW-1:0] ch_cnt,
  output logic [NUM_CH-1:0]    ch_busy,
  output logic [NUM_CH-1:0]    ch_done
);

  localparam longint DIV_L = calc_div(CLK_HZ, BASE_NS);
  localparam int     DIV   = int'(DIV_L);
  localparam int     PRE_W = $clog2(DIV);

  if (!div_exact(CLK_HZ, BASE_NS) || DIV_L < 2) begin : g_div_chk
    $error("counter_timebase: CLK_HZ*BASE_NS/1e9 must be an integer >= 2");
  end

  if (NUM_CH < 1 || NUM_CH > 8) begin : g_ch_chk
    $error("counter_timebase: NUM_CH must be within 1..8");
  end

  logic [PRE_W-1:0] pre_cnt;
  logic             pre_wrap;

  assign pre_wrap = (pre_cnt == PRE_W'(DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt   <= '0;
      base_tick <= 1'b0;
    end else if (!en) begin
      pre_cnt   <= '0;
      base_tick <= 1'b0;
    end else begin
      base_tick <= pre_wrap;
      pre_cnt   <= pre_wrap ? '0 : pre_cnt + PRE_W'(1);
    end
  end

  // A base_tick left over from the cycle en fell must not advance channels.
  logic ch_adv;
  assign ch_adv = base_tick & en;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    counter_timebase_ch #(
      .PW(PW)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .advance(ch_adv),
      .ch_en  (ch_en[k]),
      .period (ch_period[k*PW +: PW]),
      .oneshot(ch_oneshot[k]),
      .tick   (ch_tick[k]),
      .cnt    (ch_cnt[k*PW +: PW]),
      .busy   (ch_busy[k]),
      .done   (ch_done[k])
    );
  end

endmodule

// File: tb/tb_counter_timebase.sv
// Self-checking bench for counter_timebase (defaults: DIV=20, 2 ch, PW=8).
// Honors COUNTER_TIMEBASE_ONESHOT_EN to pick the expected channel modes.
module tb_counter_timebase;

  localparam int DIV    = 20;
  localparam int NUM_CH = 2;
  localparam int PW     = 8;
`ifdef COUNTER_TIMEBASE_ONESHOT_EN
  localparam bit OS = 1'b1;
`else
  localparam bit OS = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 en;
  logic [NUM_CH-1:0]    ch_en;
  logic [NUM_CH*PW-1:0] ch_period;
  logic [NUM_CH-1:0]    ch_oneshot;
  logic                 base_tick;
  logic [NUM_CH-1:0]    ch_tick;
  logic [NUM_CH*PW-1:0] ch_cnt;
  logic [NUM_CH-1:0]    ch_busy;
  logic [NUM_CH-1:0]    ch_done;

  counter_timebase #(
    .CLK_HZ (20_000_000),
    .BASE_NS(1000),
    .NUM_CH (NUM_CH),
    .PW     (PW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .ch_en     (ch_en),
    .ch_period (ch_period),
    .ch_oneshot(ch_oneshot),
    .base_tick (base_tick),
    .ch_tick   (ch_tick),
    .ch_cnt    (ch_cnt),
    .ch_busy   (ch_busy),
    .ch_done   (ch_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Model: base tick after every DIV-th consecutive enabled edge; channels
  // count those ticks against the period captured at start / last wrap.
  int m_pre;
  bit m_bt;
  int m_st  [NUM_CH];
  int m_cnt [NUM_CH];
  int m_per [NUM_CH];
  bit m_one [NUM_CH];
  bit m_tick[NUM_CH];

  always @(posedge clk or posedge rst) begin
    bit adv;
    int p;
    if (rst) begin
      m_pre = 0;
      m_bt  = 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
        m_st[k] = 0; m_cnt[k] = 0; m_per[k] = 0;
        m_one[k] = 1'b0; m_tick[k] = 1'b0;
      end
    end else begin
      adv = m_bt && en;
      for (int k = 0; k < NUM_CH; k++) begin
        p = int'(ch_period[k*PW +: PW]);
        m_tick[k] = 1'b0;
        if (!ch_en[k]) begin
          m_st[k] = 0; m_cnt[k] = 0;
        end else if (m_st[k] == 0) begin
          if (p != 0) begin
            m_st[k] = 1; m_per[k] = p; m_cnt[k] = 0;
            m_one[k] = OS && ch_oneshot[k];
          end
        end else if (m_st[k] == 1 && adv) begin
          if (m_cnt[k] + 1 == m_per[k]) begin
            m_cnt[k] = 0;
            m_tick[k] = 1'b1;
            if (m_one[k]) m_st[k] = 2;
            else begin
              m_per[k] = p;
              if (p == 0) m_st[k] = 0;
            end
          end else begin
            m_cnt[k]++;
          end
        end
      end
      if (en) begin
        m_pre++;
        m_bt = (m_pre % DIV) == 0;
      end else begin
        m_pre = 0;
        m_bt  = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    chk("base_tick", 32'(base_tick), 32'(m_bt));
    for (int k = 0; k < NUM_CH; k++) begin
      chk($sformatf("ch_tick[%0d]", k), 32'(ch_tick[k]), 32'(m_tick[k]));
      chk($sformatf("ch_cnt[%0d]", k), 32'(ch_cnt[k*PW +: PW]),
          32'(m_cnt[k]));
      chk($sformatf("ch_busy[%0d]", k), 32'(ch_busy[k]),
          32'(m_st[k] == 1));
      chk($sformatf("ch_done[%0d]", k), 32'(ch_done[k]),
          32'(m_st[k] == 2));
    end
  end

  int tick_cnt[NUM_CH];
  initial for (int k = 0; k < NUM_CH; k++) tick_cnt[k] = 0;
  always @(negedge clk)
    for (int k = 0; k < NUM_CH; k++)
      if (ch_tick[k] === 1'b1) tick_cnt[k]++;

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  // which: 0 = base_tick, 1+k = ch_tick[k]; n = -1 on timeout
  task automatic wait_sig(input int which, input int lim, output int n);
    logic s;
    n = -1;
    for (int i = 1; i <= lim; i++) begin
      edge1();
      s = (which == 0) ? base_tick : ch_tick[which-1];
      if (s === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  int n;
  int start;
  bit found;

  initial begin
    rst = 1'b1; en = 1'b0; ch_en = '0; ch_period = '0; ch_oneshot = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_base_tick", 32'(base_tick), 0);
    chk("rst_ch_busy", 32'(ch_busy), 0);
    chk("rst_ch_cnt", 32'(ch_cnt), 0);
    #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    #2 en = 1'b1;

    wait_sig(0, 40, n);
    chk("first_base_tick_edge", n, 20);
    wait_sig(0, 40, n);
    chk("base_tick_interval", n, 20);

    #1;
    ch_period[7:0] = 8'd3;
    ch_en[0] = 1'b1;
    wait_sig(1, 200, n);
    chk("ch0_first_tick_seen", 32'(n > 0), 1);
    wait_sig(1, 200, n);
    chk("ch0_tick_interval", n, 60);
    chk("ch0_cnt_seq0", 32'(ch_cnt[7:0]), 0);
    for (int j = 1; j <= 3; j++) begin
      wait_sig(0, 40, n);
      edge1();
      chk($sformatf("ch0_cnt_seq%0d", j), 32'(ch_cnt[7:0]), j % 3);
    end
    chk("ch0_tick_at_wrap", 32'(ch_tick[0]), 1);

    #1 ch_period[7:0] = 8'd5;
    wait_sig(1, 200, n);
    chk("period_old_interval", n, 60);
    wait_sig(1, 300, n);
    chk("period_new_interval", n, 100);

    #1 ch_en[1] = 1'b1;
    start = tick_cnt[1];
    repeat (100) edge1();
    chk("p0_busy", 32'(ch_busy[1]), 0);
    chk("p0_ticks", tick_cnt[1] - start, 0);
    #1 ch_en[0] = 1'b0;
    edge1();
    chk("dis_cnt", 32'(ch_cnt[7:0]), 0);
    chk("dis_busy", 32'(ch_busy[0]), 0);

    #1;
    ch_period[15:8] = 8'd2;
    ch_oneshot[1] = 1'b1;
    wait_sig(2, 200, n);
    chk("ch1_tick_seen", 32'(n > 0), 1);
`ifdef COUNTER_TIMEBASE_ONESHOT_EN
    chk("os_busy_drop", 32'(ch_busy[1]), 0);
    chk("os_done_set", 32'(ch_done[1]), 1);
    start = tick_cnt[1];
    repeat (100) edge1();
    chk("os_done_hold", 32'(ch_done[1]), 1);
    chk("os_single_tick", tick_cnt[1] - start, 0);
    #1 ch_en[1] = 1'b0;
    edge1();
    chk("os_idle_done", 32'(ch_done[1]), 0);
    chk("os_idle_busy", 32'(ch_busy[1]), 0);
    #1 ch_en[1] = 1'b1;
    edge1();
    chk("os_restart_busy", 32'(ch_busy[1]), 1);
    chk("os_restart_cnt", 32'(ch_cnt[15:8]), 0);
`else
    chk("nomacro_done", 32'(ch_done[1]), 0);
    chk("nomacro_busy", 32'(ch_busy[1]), 1);
    repeat (100) edge1();
    chk("nomacro_done_hold", 32'(ch_done), 0);
`endif
    #1;
    ch_en[1] = 1'b0;
    ch_oneshot = '0;

    ch_period[7:0] = 8'd2;
    ch_en[0] = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      edge1();
      if (ch_cnt[7:0] == 8'd1 && base_tick === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    chk("tc_found", 32'(found), 1);
    #1 ch_en[0] = 1'b0;
    start = tick_cnt[0];
    edge1();
    chk("tc_dis_tick", 32'(ch_tick[0]), 0);
    chk("tc_dis_cnt", 32'(ch_cnt[7:0]), 0);
    repeat (3) edge1();
    chk("tc_dis_no_tick", tick_cnt[0] - start, 0);

    #1;
    ch_period[7:0] = 8'd5;
    ch_en[0] = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      edge1();
      if (ch_cnt[7:0] == 8'd2) begin
        found = 1'b1;
        break;
      end
    end
    chk("mid_cnt2_found", 32'(found), 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_cnt", 32'(ch_cnt), 0);
    chk("async_rst_busy", 32'(ch_busy), 0);
    chk("async_rst_tick", 32'({base_tick, ch_tick, ch_done}), 0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    edge1();
    chk("post_rst_busy", 32'(ch_busy[0]), 1);
    chk("post_rst_cnt", 32'(ch_cnt[7:0]), 0);
    wait_sig(0, 40, n);
    chk("post_rst_bt", n, 19);
    edge1();
    chk("post_rst_cnt1", 32'(ch_cnt[7:0]), 1);

    #1 en = 1'b0;
    start = tick_cnt[0];
    repeat (50) edge1();
    chk("en0_hold_cnt", 32'(ch_cnt[7:0]), 1);
    chk("en0_hold_busy", 32'(ch_busy[0]), 1);
    chk("en0_no_tick", tick_cnt[0] - start, 0);
    #1 en = 1'b1;
    repeat (200) edge1();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/counter_timebase.md
COUNTER_TIMEBASE -- requirements
Module: counter_timebase

Interface
REQ-001 SHALL have parameter CLK_HZ, default 20_000_000, input clock frequency in Hz.
REQ-002 SHALL have parameter BASE_NS, default 1000, base tick period in ns; DIV = CLK_HZ*BASE_NS/1e9 SHALL be an integer >= 2, checked at elaboration.
REQ-003 SHALL have parameter NUM_CH, default 2, number of independent channels (1..8).
REQ-004 SHALL have parameter PW, default 8, channel period/count width in bits.
REQ-005 SHALL have port clk  in  1  sole clock, rising edge.
REQ-006 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-007 SHALL have port en  in  1  global enable for the prescaler.
REQ-008 SHALL have port ch_en  in  NUM_CH  per-channel run request, level-sensitive.
REQ-009 SHALL have port ch_period  in  NUM_CH*PW  per-channel period in base ticks; channel k uses bits [k*PW +: PW].
REQ-010 SHALL have port ch_oneshot  in  NUM_CH  per-channel mode select: 1 = one-shot, 0 = periodic.
REQ-011 SHALL have port base_tick  out  1  one-clk pulse every DIV enabled cycles.
REQ-012 SHALL have port ch_tick  out  NUM_CH  one-clk pulse at each channel terminal count.
REQ-013 SHALL have port ch_cnt  out  NUM_CH*PW  current base-tick count per channel.
REQ-014 SHALL have port ch_busy  out  NUM_CH  channel is in RUN.
REQ-015 SHALL have port ch_done  out  NUM_CH  one-shot channel has completed.

Function
REQ-016 Prescaler: while en=1, SHALL count 0..DIV-1 and wrap; while en=0, SHALL clear to 0 with base_tick=0.
REQ-017 base_tick SHALL be registered and high exactly one cycle; the first pulse SHALL occur on the DIV-th rising edge at which en is sampled 1.
REQ-018 Each channel SHALL be an FSM with states IDLE, RUN and DONE.
REQ-019 IDLE->RUN when ch_en=1 and the period is nonzero; ch_period SHALL be latched on that edge; cnt=0, busy=1.
REQ-020 ch_en=1 with ch_period=0 SHALL keep the channel in IDLE with no ticks.
REQ-021 In RUN, each base_tick SHALL increment cnt; when cnt = latched period-1, cnt SHALL go to 0 and ch_tick SHALL be high for the next clk cycle (one-cycle latency after base_tick).
REQ-022 Periodic mode: at wrap, the channel SHALL re-latch ch_period (new value takes effect from the next cycle), or go to IDLE if the new value is 0.
REQ-023 One-shot mode: at terminal count the channel SHALL emit ch_tick, go to DONE with busy=0 and done=1, and hold DONE until ch_en=0, then go to IDLE.
REQ-024 ch_en=0 in any state SHALL force IDLE on the next edge: cnt=0, busy=0, done=0.
REQ-025 If ch_en falls in the same cycle as the terminal count, disable SHALL win and no ch_tick SHALL be issued.
REQ-026 ch_oneshot SHALL be sampled only at IDLE->RUN.
REQ-027 While en=0, channels SHALL hold cnt and state; no ticks SHALL be issued.

Reset
REQ-028 rst=1 SHALL immediately clear the prescaler, all cnt/latched periods, base_tick, ch_tick, ch_busy and ch_done, and put all channels in IDLE, including mid-count.
REQ-029 After rst falls, the first prescaler increment SHALL occur on the first rising edge with en=1.

Configuration
REQ-030 The macro COUNTER_TIMEBASE_ONESHOT_EN SHALL control one-shot support.
REQ-031 With COUNTER_TIMEBASE_ONESHOT_EN defined, behaviour SHALL be per REQ-023.
REQ-032 Without COUNTER_TIMEBASE_ONESHOT_EN, ch_oneshot SHALL be ignored, all channels SHALL be periodic, DONE SHALL not exist, and ch_done SHALL be tied to 0.

Structure
REQ-033 Package counter_timebase_pkg SHALL hold the channel state enum (IDLE/RUN/DONE) and a DIV computation function/constant.
REQ-034 Sub-module counter_timebase_ch SHALL implement one channel and be instantiated NUM_CH times via generate; the prescaler SHALL live in the top.

Verification
REQ-035 Defaults, en=1 after reset release: base_tick every 20 clk (1 us); first pulse 20 edges after en sampled high.
REQ-036 ch0 periodic, period=3: ch_tick every 60 clk (3 us), 1 clk after every third base_tick; ch_cnt sequence 0,1,2,0.
REQ-037 ch1 one-shot, period=2: single ch_tick; busy drops and done=1; done holds until ch_en=0, then IDLE; re-enable restarts.
REQ-038 ch_en dropped on the cycle of terminal count: no ch_tick, cnt=0 next cycle.
REQ-039 rst pulsed mid-count (cnt=2): all outputs 0 immediately, asynchronously; channel re-runs from 0 after release.
REQ-040 Period 0 gives no busy and no ticks; periodic period change 3->5 takes effect only after the next wrap; build without the macro gives ch_done=0 always.
